lcd1602_bus_writer: RTL and testbench

Byte-level HD44780/LCD1602 bus driver that sits directly downstream of the LCD command sequencer. It accepts (RS, byte) write requests through a valid/ready handshake and buffers them in a small FIFO. It drives the 8-bit parallel bus with correct setup, EN-pulse and hold timing, then waits the controller execution time before issuing the next write. The sequencer no longer derives EN from a slow divider; it only pushes bytes.

---
 rtl/lcd1602_bus_writer.sv | 136 +++++++++++++
 tb/tb_lcd1602_bus_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_bus_writer.sv
// HD44780/LCD1602 byte writer: buffers (RS, byte) requests in a small FIFO and
// plays each one onto the 8-bit bus with setup / EN pulse / hold / execution timing.
module lcd1602_bus_writer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned T_PWRUP     = 405000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN_HIGH   = 13,
    parameter int unsigned T_HOLD      = 1,
    parameter int unsigned T_EXEC      = 1000,
    parameter int unsigned T_EXEC_LONG = 41040
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, PULSE, HOLD, EXEC} state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [7:0]  data_q;
    logic        rs_q;
    logic        en_q;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [8:0]  mem_q [DEPTH];

    logic        full, empty, push, pop, cnt_zero, long_exec;
    logic [8:0]  head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push     = in_valid && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign head     = mem_q[rptr_q[AW-1:0]];
    assign wptr_d   = wptr_q + (AW+1)'(push);
    assign rptr_d   = rptr_q + (AW+1)'(pop);
    assign cnt_zero = (cnt_q == 32'd0);

    // Clear and return-home are the slow controller instructions.
    assign long_exec = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= {in_rs, in_data};
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= PWRUP;
            cnt_q   <= T_PWRUP - 1;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_zero) state_q <= IDLE;
                    else          cnt_q   <= cnt_q - 1;
                end
                IDLE: begin
                    if (!empty) begin
                        data_q  <= head[7:0];
                        rs_q    <= head[8];
                        state_q <= SETUP;
                        cnt_q   <= T_SETUP - 1;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state_q <= PULSE;
                        en_q    <= 1'b1;
                        cnt_q   <= T_EN_HIGH - 1;
                    end else begin
                        cnt_q   <= cnt_q - 1;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        state_q <= HOLD;
                        en_q    <= 1'b0;
                        cnt_q   <= T_HOLD - 1;
                    end else begin
                        cnt_q   <= cnt_q - 1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state_q <= EXEC;
                        cnt_q   <= long_exec ? T_EXEC_LONG - 1 : T_EXEC - 1;
                    end else begin
                        cnt_q   <= cnt_q - 1;
                    end
                end
                EXEC: begin
                    if (cnt_zero) state_q <= IDLE;
                    else          cnt_q   <= cnt_q - 1;
                end
                default: begin
                    state_q <= PWRUP;
                    en_q    <= 1'b0;
                    cnt_q   <= T_PWRUP - 1;
                end
            endcase
        end
    end

    assign in_ready = !full;
    assign busy     = (state_q != IDLE) || !empty;
    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;

endmodule

// File: tb/tb_lcd1602_bus_writer.sv
// Bench for lcd1602_bus_writer: a write-schedule reference model checks every
// cycle, plus a vector table and directed sequences for the timing corners.
module tb_lcd1602_bus_writer;
    localparam int DEPTH = 4, TPW = 10, TS = 2, TE = 3, TH = 1, TX = 5, TXL = 20;

    logic       iclk = 1'b0;
    logic       irst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    always #5 iclk = ~iclk;

    lcd1602_bus_writer #(
        .DEPTH(DEPTH), .T_PWRUP(TPW), .T_SETUP(TS), .T_EN_HIGH(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL)
    ) dut (
        .iclk(iclk), .irst(irst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .busy(busy), .LCD_DATA(LCD_DATA),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
    );

    int checks = 0, errors = 0;

    // Reference model: a queue of accepted writes and the schedule of the current one.
    int         cyc, free_at, rise_at, fall_at;
    logic [8:0] mq[$];
    logic [7:0] m_data;
    logic       m_rs;

    // Observed bus events.
    int         rises[$], falls[$];
    logic [8:0] rise_val[$];
    logic       prev_en, prev_busy;
    int         busy_fall;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_rise;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cyc = 0; free_at = TPW + 1; rise_at = -1000; fall_at = -1000;
        m_data = 8'h00; m_rs = 1'b0;
        rises.delete(); falls.delete(); rise_val.delete();
        prev_en = 1'b0; prev_busy = 1'b1; busy_fall = -1;
    endtask

    // One edge of the model: a pop uses the pre-edge queue, then a push if there was room.
    task automatic model_edge();
        int occ0;
        logic [8:0] e;
        occ0 = mq.size();
        cyc++;
        if (occ0 > 0 && cyc >= free_at) begin
            e = mq.pop_front();
            m_rs = e[8]; m_data = e[7:0];
            rise_at = cyc + TS;
            fall_at = rise_at + TE;
            free_at = fall_at + TH + ((!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? TXL : TX) + 1;
        end
        if (in_valid && occ0 < DEPTH) mq.push_back({in_rs, in_data});
    endtask

    task automatic check_outputs();
        chk("en",       LCD_EN,   32'(cyc >= rise_at && cyc < fall_at));
        chk("data",     LCD_DATA, m_data);
        chk("rs",       LCD_RS,   m_rs);
        chk("rw",       LCD_RW,   0);
        chk("busy",     busy,     32'(mq.size() != 0 || cyc < free_at - 1));
        chk("in_ready", in_ready, 32'(mq.size() < DEPTH));
        if (LCD_EN && !prev_en) begin
            rises.push_back(cyc);
            rise_val.push_back({LCD_RS, LCD_DATA});
        end
        if (!LCD_EN && prev_en) falls.push_back(cyc);
        if (!busy && prev_busy) busy_fall = cyc;
        prev_en = LCD_EN;
        prev_busy = busy;
    endtask

    task automatic step(input logic v, input logic rs, input logic [7:0] d);
        in_valid = v; in_rs = rs; in_data = d;
        @(posedge iclk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        irst = 1'b0;
        repeat (2) @(negedge iclk);
        irst = 1'b1;
        model_reset();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Six writes held on in_valid from edge 1; rises 12 apart after power-up.
        vt[0] = '{1'b0, 8'h38, 13};
        vt[1] = '{1'b0, 8'h0F, 25};
        vt[2] = '{1'b1, 8'h41, 37};
        vt[3] = '{1'b0, 8'h0C, 49};
        vt[4] = '{1'b0, 8'h80, 61};
        vt[5] = '{1'b1, 8'h42, 73};

        // Reset values, then power-up gate, full FIFO back-pressure, back-to-back spacing.
        do_reset();
        chk("rst_busy", busy, 1);
        chk("rst_ready", in_ready, 1);
        begin
            int k;
            logic acc;
            k = 0;
            for (int i = 0; i < 90; i++) begin
                if (k < 6) begin
                    acc = in_ready;
                    step(1'b1, vt[k].rs, vt[k].data);
                    if (acc) k++;
                    if (i == 4) chk("ready_low_after_4", in_ready, 0);
                end else begin
                    step(1'b0, 1'b0, 8'h00);
                end
            end
            chk("all_accepted", k, 6);
        end
        chk("rise_count", rises.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rises.size()) begin
                chk("rise_time", rises[i], vt[i].exp_rise);
                chk("rise_value", rise_val[i], {vt[i].rs, vt[i].data});
            end
            if (i < falls.size()) chk("en_width", falls[i] - vt[i].exp_rise, TE);
        end
        if (falls.size() == 6) chk("busy_fall_after_last", busy_fall - falls[5], TH + TX);

        // Clear display: HOLD 1 + EXEC 20 + IDLE pop 1 + SETUP 2 from EN fall to next rise.
        do_reset();
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h14);
        idle(50);
        chk("long_rise_count", rises.size(), 2);
        if (rises.size() == 2 && falls.size() >= 1) chk("long_gap", rises[1] - falls[0], 24);

        // Data byte 0x01 is not a clear instruction: short exec.
        do_reset();
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h38);
        idle(40);
        chk("rs1_rise_count", rises.size(), 2);
        if (rises.size() == 2) chk("rs1_spacing", rises[1] - rises[0], TS + TE + TH + TX + 1);

        // Reset while EN is high with two writes still queued.
        do_reset();
        step(1'b1, 1'b0, 8'h38);
        step(1'b1, 1'b0, 8'h0F);
        step(1'b1, 1'b0, 8'h06);
        begin
            int n;
            n = 0;
            while (!LCD_EN && n < 30) begin
                step(1'b0, 1'b0, 8'h00);
                n++;
            end
            chk("reached_pulse", LCD_EN, 1);
            chk("queued_two", mq.size(), 2);
        end
        #2 irst = 1'b0;
        #1;
        chk("async_en_drop", LCD_EN, 0);
        chk("async_busy", busy, 1);
        chk("async_ready", in_ready, 1);
        @(negedge iclk);
        irst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        idle(40);
        chk("no_stale_writes", rises.size(), 0);

        // Randomized traffic against the schedule model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic       v, rs;
            logic [7:0] d;
            v  = ($urandom_range(0, 99) < 30);
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            step(v, rs, d);
        end
        idle(200);
        chk("rand_drained_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
